dm_access_arbiter: RTL and testbench

- Sequences every data-memory access issued from the MEM pipeline stage and shares the single data-memory port with an external requester (loader/DMA).
- Sits between the EX/MEM pipeline register outputs and the data memory.
- Inserts configurable wait states, stalls the pipeline while a CPU access is in flight, and guarantees the external port forward progress.

---
 rtl/dm_access_arbiter_if.sv | 39 +++
 rtl/dm_access_arbiter.sv | 82 ++++++++
 tb/tb_dm_access_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_arbiter_if.sv
// dm_access_arbiter_if: MEM-stage, external-requester and data-memory signals around the arbiter
interface dm_access_arbiter_if;
    logic        MEM_DM_WE;
    logic        MEM_DM_RE;
    logic [15:0] MEM_DM_ADDR;
    logic [31:0] MEM_muxB;
    logic        MEM_STALL;
    logic [31:0] MEM_RD_DATA;
    logic        MEM_RD_VALID;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] ext_rdata;
    logic        ext_done;
    logic        dm_we;
    logic        dm_re;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    modport master (
        input  MEM_DM_WE, MEM_DM_RE, MEM_DM_ADDR, MEM_muxB,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  dm_rdata,
        output MEM_STALL, MEM_RD_DATA, MEM_RD_VALID,
        output ext_rdata, ext_done,
        output dm_we, dm_re, dm_addr, dm_wdata
    );

    modport slave (
        output MEM_DM_WE, MEM_DM_RE, MEM_DM_ADDR, MEM_muxB,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output dm_rdata,
        input  MEM_STALL, MEM_RD_DATA, MEM_RD_VALID,
        input  ext_rdata, ext_done,
        input  dm_we, dm_re, dm_addr, dm_wdata
    );
endinterface

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares the data-memory port between MEM-stage CPU accesses and an external requester
module dm_access_arbiter #(
    parameter int WAIT_STATES   = 1,
    parameter int MAX_CPU_BURST = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    dm_access_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, CPU_ACC, EXT_ACC} state_t;

    state_t     state, state_next;
    logic [3:0] cnt, streak;
    logic       cpu_req, last, burst_full, grant_cpu, grant_ext;

    assign cpu_req       = bus.MEM_DM_WE | bus.MEM_DM_RE;
    assign last          = cnt == 4'(WAIT_STATES);
    assign burst_full    = streak == 4'(MAX_CPU_BURST);
    assign bus.MEM_STALL = cpu_req && !(state == CPU_ACC && last);

    // arbitration: the CPU wins unless a waiting external request has sat out a full CPU burst
    always_comb begin
        grant_cpu  = state == IDLE && cpu_req && !(bus.ext_req && burst_full);
        grant_ext  = state == IDLE && bus.ext_req && !grant_cpu;
        state_next = grant_cpu ? CPU_ACC :
                     grant_ext ? EXT_ACC :
                     (state != IDLE && last) ? IDLE : state;
    end

    // state, wait-state counter and fairness streak
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            streak <= '0;
        end else begin
            state  <= state_next;
            cnt    <= (state == IDLE || last) ? '0 : cnt + 4'd1;
            streak <= (!bus.ext_req || grant_ext) ? '0 :
                      (grant_cpu && !burst_full) ? streak + 4'd1 : streak;
        end
    end

    // memory strobes latched at grant and dropped at completion; read data captured on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dm_we        <= 1'b0;
            bus.dm_re        <= 1'b0;
            bus.dm_addr      <= '0;
            bus.dm_wdata     <= '0;
            bus.MEM_RD_DATA  <= '0;
            bus.MEM_RD_VALID <= 1'b0;
            bus.ext_rdata    <= '0;
            bus.ext_done     <= 1'b0;
        end else begin
            bus.MEM_RD_VALID <= 1'b0;
            bus.ext_done     <= 1'b0;
            if (grant_cpu) begin
                bus.dm_we    <= bus.MEM_DM_WE;
                bus.dm_re    <= bus.MEM_DM_RE & ~bus.MEM_DM_WE;
                bus.dm_addr  <= bus.MEM_DM_ADDR;
                bus.dm_wdata <= bus.MEM_muxB;
            end else if (grant_ext) begin
                bus.dm_we    <= bus.ext_we;
                bus.dm_re    <= ~bus.ext_we;
                bus.dm_addr  <= bus.ext_addr;
                bus.dm_wdata <= bus.ext_wdata;
            end else if (state != IDLE && last) begin
                bus.dm_we <= 1'b0;
                bus.dm_re <= 1'b0;
                if (state == CPU_ACC && bus.dm_re) begin
                    bus.MEM_RD_DATA  <= bus.dm_rdata;
                    bus.MEM_RD_VALID <= 1'b1;
                end
                if (state == EXT_ACC) begin
                    bus.ext_done <= 1'b1;
                    if (bus.dm_re) bus.ext_rdata <= bus.dm_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter: directed scoreboard bench for the data-memory access arbiter
module tb_dm_access_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dm_access_arbiter_if bus();
    dm_access_arbiter #(.WAIT_STATES(1), .MAX_CPU_BURST(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] cpu_q[$];
    logic [31:0] ext_q[$];
    logic [15:0] grant_q[$];
    logic [31:0] ext_hold = '0;

    // behavioural memory: unwritten words return an address-derived pattern
    logic [31:0]  mem [256];
    logic [255:0] written = '0;
    always @(posedge clk) if (bus.dm_we) begin
        mem[bus.dm_addr[7:0]]     <= bus.dm_wdata;
        written[bus.dm_addr[7:0]] <= 1'b1;
    end
    always_comb bus.dm_rdata = written[bus.dm_addr[7:0]] ? mem[bus.dm_addr[7:0]] :
                               (bus.dm_addr == 16'h0010) ? 32'hDEADBEEF : {~bus.dm_addr, bus.dm_addr};

    function automatic logic [31:0] expect_rd(input logic [15:0] a);
        return written[a[7:0]] ? mem[a[7:0]] : (a == 16'h0010) ? 32'hDEADBEEF : {~a, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // monitor: strobe counting, grant log, hold checks and scoreboard pops
    int   re_cycles = 0, we_cycles = 0, valid_cnt = 0, done_cnt = 0;
    logic prev_active = 1'b0, prev_valid = 1'b0, prev_done = 1'b0, active;
    logic [15:0] held_addr;
    logic [31:0] held_wdata;
    logic [1:0]  held_str;
    always @(negedge clk) begin
        active = bus.dm_re | bus.dm_we;
        if (bus.dm_re) re_cycles++;
        if (bus.dm_we) we_cycles++;
        if (active && !prev_active) begin
            grant_q.push_back(bus.dm_addr);
            held_addr  = bus.dm_addr;
            held_wdata = bus.dm_wdata;
            held_str   = {bus.dm_we, bus.dm_re};
        end else if (active) begin
            check("held_addr", 32'(bus.dm_addr), 32'(held_addr));
            check("held_wdata", bus.dm_wdata, held_wdata);
            check("held_strobes", 32'({bus.dm_we, bus.dm_re}), 32'(held_str));
        end
        if (bus.MEM_RD_VALID) begin
            valid_cnt++;
            check("rd_valid_single_cycle", 32'(prev_valid), 32'(0));
            check("rd_valid_expected", 32'(cpu_q.size() != 0), 32'(1));
            if (cpu_q.size() != 0) check("cpu_rd_data", bus.MEM_RD_DATA, cpu_q.pop_front());
        end
        if (bus.ext_done) begin
            done_cnt++;
            check("ext_done_single_cycle", 32'(prev_done), 32'(0));
            check("ext_done_expected", 32'(ext_q.size() != 0), 32'(1));
            if (ext_q.size() != 0) check("ext_rdata", bus.ext_rdata, ext_q.pop_front());
        end
        prev_active = active;
        prev_valid  = bus.MEM_RD_VALID;
        prev_done   = bus.ext_done;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic re, input logic [15:0] addr,
                              input logic [31:0] wdata, output int stalls);
        bus.MEM_DM_WE   = we;
        bus.MEM_DM_RE   = re;
        bus.MEM_DM_ADDR = addr;
        bus.MEM_muxB    = wdata;
        if (re && !we) cpu_q.push_back(expect_rd(addr));
        stalls = 0;
        @(negedge clk);
        while (bus.MEM_STALL && stalls < 64) begin
            stalls++;
            @(negedge clk);
        end
        check("cpu_stall_released", 32'(bus.MEM_STALL), 32'(0));
        @(posedge clk);
        #1;
        bus.MEM_DM_WE = 1'b0;
        bus.MEM_DM_RE = 1'b0;
    endtask

    task automatic ext_access(input logic we, input logic [15:0] addr,
                              input logic [31:0] wdata, output int cycles);
        bus.ext_req   = 1'b1;
        bus.ext_we    = we;
        bus.ext_addr  = addr;
        bus.ext_wdata = wdata;
        if (!we) ext_hold = expect_rd(addr);
        ext_q.push_back(ext_hold);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!bus.ext_done && cycles < 64);
        check("ext_done_seen", 32'(bus.ext_done), 32'(1));
        bus.ext_req = 1'b0;
    endtask

    task automatic check_grant(input string tag, input logic [15:0] a);
        logic [15:0] g;
        g = (grant_q.size() != 0) ? grant_q.pop_front() : 16'hFFFF;
        check(tag, 32'(g), 32'(a));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    int st, c1, c2, r0, w0, v0, d0;
    int st_log[6];

    initial begin
        rst_n = 1'b0;
        bus.MEM_DM_WE = 1'b0; bus.MEM_DM_RE = 1'b0; bus.MEM_DM_ADDR = '0; bus.MEM_muxB = '0;
        bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
        @(negedge clk);
        check("rst_dm_we", 32'(bus.dm_we), 32'(0));
        check("rst_dm_re", 32'(bus.dm_re), 32'(0));
        check("rst_dm_addr", 32'(bus.dm_addr), 32'(0));
        check("rst_dm_wdata", bus.dm_wdata, 32'(0));
        check("rst_rd_data", bus.MEM_RD_DATA, 32'(0));
        check("rst_rd_valid", 32'(bus.MEM_RD_VALID), 32'(0));
        check("rst_ext_rdata", bus.ext_rdata, 32'(0));
        check("rst_ext_done", 32'(bus.ext_done), 32'(0));
        check("rst_stall", 32'(bus.MEM_STALL), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        r0 = re_cycles; v0 = valid_cnt;
        cpu_access(1'b0, 1'b1, 16'h0010, 32'h0, st);
        check("t1_stall_cycles", 32'(st), 32'(2));
        check("t1_valid_after_stall", 32'(bus.MEM_RD_VALID), 32'(1));
        check("t1_rd_data", bus.MEM_RD_DATA, 32'hDEADBEEF);
        idle(1);
        check("t1_re_cycles", 32'(re_cycles - r0), 32'(2));
        check("t1_valid_count", 32'(valid_cnt - v0), 32'(1));
        check("t1_valid_cleared", 32'(bus.MEM_RD_VALID), 32'(0));

        w0 = we_cycles; v0 = valid_cnt;
        cpu_access(1'b1, 1'b0, 16'h0020, 32'h12345678, st);
        idle(1);
        check("t2_stall_cycles", 32'(st), 32'(2));
        check("t2_we_cycles", 32'(we_cycles - w0), 32'(2));
        check("t2_no_valid", 32'(valid_cnt - v0), 32'(0));
        check("t2_data_held", bus.MEM_RD_DATA, 32'hDEADBEEF);
        cpu_access(1'b0, 1'b1, 16'h0020, 32'h0, st);
        idle(1);
        check("t2_readback", bus.MEM_RD_DATA, 32'h12345678);

        grant_q.delete();
        d0 = done_cnt;
        fork
            ext_access(1'b0, 16'h8004, 32'h0, c1);
            cpu_access(1'b0, 1'b1, 16'h0030, 32'h0, st);
        join
        idle(1);
        check("t3_cpu_stall", 32'(st), 32'(2));
        check_grant("t3_grant_cpu_first", 16'h0030);
        check_grant("t3_grant_ext_second", 16'h8004);
        check("t3_ext_done_count", 32'(done_cnt - d0), 32'(1));

        grant_q.delete();
        fork
            ext_access(1'b0, 16'h8008, 32'h0, c1);
            begin
                for (int i = 0; i < 6; i++) begin
                    cpu_access(1'b0, 1'b1, 16'h0040 + 16'(i), 32'h0, st);
                    st_log[i] = st;
                end
            end
        join
        idle(1);
        for (int i = 0; i < 4; i++) check_grant("t4_grant_cpu_burst", 16'h0040 + 16'(i));
        check_grant("t4_grant_ext_forced", 16'h8008);
        check_grant("t4_grant_cpu_resume", 16'h0044);
        check_grant("t4_grant_cpu_resume", 16'h0045);
        check("t4_stall_burst", 32'(st_log[3]), 32'(2));
        check("t4_stall_over_ext", 32'(st_log[4]), 32'(5));
        check("t4_stall_resume", 32'(st_log[5]), 32'(2));

        r0 = re_cycles; w0 = we_cycles; v0 = valid_cnt;
        cpu_access(1'b1, 1'b1, 16'h0050, 32'hA5A55A5A, st);
        idle(1);
        check("t5_re_cycles", 32'(re_cycles - r0), 32'(0));
        check("t5_we_cycles", 32'(we_cycles - w0), 32'(2));
        check("t5_no_valid", 32'(valid_cnt - v0), 32'(0));
        check("t5_mem_written", mem[8'h50], 32'hA5A55A5A);

        ext_access(1'b1, 16'h8060, 32'hCAFEF00D, c1);
        ext_access(1'b0, 16'h8060, 32'h0, c2);
        idle(1);
        check("t7_ext_write_cycles", 32'(c1), 32'(3));
        check("t7_ext_read_cycles", 32'(c2), 32'(3));
        check("t7_ext_readback", bus.ext_rdata, 32'hCAFEF00D);

        d0 = done_cnt;
        bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 16'h800C;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("t6_re_before_reset", 32'(bus.dm_re), 32'(1));
        rst_n = 1'b0;
        #1;
        check("t6_re_async_drop", 32'(bus.dm_re), 32'(0));
        check("t6_addr_async_clear", 32'(bus.dm_addr), 32'(0));
        check("t6_ext_rdata_clear", bus.ext_rdata, 32'(0));
        bus.ext_req = 1'b0;
        #2 rst_n = 1'b1;
        ext_hold = '0;
        repeat (3) @(negedge clk);
        check("t6_no_ext_done", 32'(done_cnt - d0), 32'(0));
        idle(1);
        cpu_access(1'b0, 1'b1, 16'h0010, 32'h0, st);
        idle(1);
        check("t6_cpu_after_reset_stall", 32'(st), 32'(2));
        check("t6_cpu_after_reset_data", bus.MEM_RD_DATA, 32'hDEADBEEF);

        check("cpu_q_drained", 32'(cpu_q.size()), 32'(0));
        check("ext_q_drained", 32'(ext_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
